// File: rtl/regfile_sb_if.sv
// Writeback, read, issue and status signals between the pipeline and the register file.
interface regfile_sb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              rdy;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              busy1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic              busy2;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic              sb_err;

  modport master (
    output rdy, we, waddr, wdata, re1, raddr1, re2, raddr2, iss_en, iss_addr,
    input  rdata1, busy1, rdata2, busy2, sb_err
  );

  modport slave (
    input  rdy, we, waddr, wdata, re1, raddr1, re2, raddr2, iss_en, iss_addr,
    output rdata1, busy1, rdata2, busy2, sb_err
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file x0..x31 with per-register in-flight writer counters.
// One WB write per cycle, two combinational read ports with WB bypass and
// busy flags that ID uses to stall on operands still owed by EX/MEM/WB.
module regfile_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 2
) (
  input  logic           clk,
  input  logic           rst,
  regfile_sb_if.slave    bus
);
  localparam int unsigned NREG = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [CNT_W-1:0]  cnt_q  [NREG];
  logic [CNT_W-1:0]  cnt_d  [NREG];
  logic              sb_err_q;
  logic              sb_err_d;
  logic [NREG-1:0]   inc_v;
  logic [NREG-1:0]   dec_v;

  // One-hot issue / writeback strobes; x0 never tracked.
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    if (bus.iss_en && (bus.iss_addr != '0)) inc_v[bus.iss_addr] = 1'b1;
    if (bus.we && (bus.waddr != '0))        dec_v[bus.waddr]    = 1'b1;
  end

  // Counter next state: saturate at both ends and flag the attempt.
  always_comb begin
    sb_err_d = sb_err_q;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc_v[r] && !dec_v[r]) begin
        if (cnt_q[r] == CNT_MAX) sb_err_d = 1'b1;
        else                     cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (dec_v[r] && !inc_v[r]) begin
        if (cnt_q[r] == '0) sb_err_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
  end

  // State update; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      sb_err_q <= 1'b0;
    end else if (bus.rdy) begin
      if (bus.we && (bus.waddr != '0)) regs_q[bus.waddr] <= bus.wdata;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      sb_err_q <= sb_err_d;
    end
  end

  logic act1, act2, hit1, hit2;

  // Read ports: x0/disabled read zero, same-cycle WB bypassed, busy clears
  // only when the WB in flight is the last pending writer.
  assign act1 = !rst && bus.re1 && (bus.raddr1 != '0);
  assign act2 = !rst && bus.re2 && (bus.raddr2 != '0);
  assign hit1 = bus.we && (bus.waddr == bus.raddr1);
  assign hit2 = bus.we && (bus.waddr == bus.raddr2);

  assign bus.rdata1 = !act1 ? '0 : (hit1 ? bus.wdata : regs_q[bus.raddr1]);
  assign bus.rdata2 = !act2 ? '0 : (hit2 ? bus.wdata : regs_q[bus.raddr2]);
  assign bus.busy1  = act1 && ((cnt_q[bus.raddr1] - CNT_W'(hit1)) != '0);
  assign bus.busy2  = act2 && ((cnt_q[bus.raddr2] - CNT_W'(hit2)) != '0);
  assign bus.sb_err = sb_err_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Randomized scoreboard bench for regfile_sb with a behavioural reference model.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] d1;
    logic        b1;
    logic [31:0] d2;
    logic        b2;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: architectural registers, pending-writer counts, sticky error.
  logic [31:0] m_reg [32];
  int          m_cnt [32];
  bit          m_err;
  localparam int CMAX = 3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void rd_model(input logic re, input logic [4:0] a,
                                   output logic [31:0] d, output logic b);
    int  ai;
    bit  hit;
    ai  = int'(a);
    hit = bus.we && (bus.waddr == a);
    if (rst || !re || ai == 0) begin
      d = '0;
      b = 1'b0;
    end else begin
      d = hit ? bus.wdata : m_reg[ai];
      b = (m_cnt[ai] - int'(hit)) != 0;
    end
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    rd_model(bus.re1, bus.raddr1, e.d1, e.b1);
    rd_model(bus.re2, bus.raddr2, e.d2, e.b2);
    e.err = m_err;
    return e;
  endfunction

  task automatic model_update();
    int wa, ia;
    bit inc, dec;
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        m_reg[r] = '0;
        m_cnt[r] = 0;
      end
      m_err = 1'b0;
    end else if (bus.rdy) begin
      wa  = int'(bus.waddr);
      ia  = int'(bus.iss_addr);
      inc = bus.iss_en && ia != 0;
      dec = bus.we && wa != 0;
      if (dec) m_reg[wa] = bus.wdata;
      if (!(inc && dec && ia == wa)) begin
        if (inc) begin
          if (m_cnt[ia] == CMAX) m_err = 1'b1;
          else                   m_cnt[ia]++;
        end
        if (dec) begin
          if (m_cnt[wa] == 0) m_err = 1'b1;
          else                m_cnt[wa]--;
        end
      end
    end
  endtask

  task automatic set_in(input bit rs, input bit rd, input bit we, input int wa,
                        input logic [31:0] wd, input bit r1, input int a1,
                        input bit r2, input int a2, input bit ie, input int ia);
    rst          = rs;
    bus.rdy      = rd;
    bus.we       = we;
    bus.waddr    = 5'(wa);
    bus.wdata    = wd;
    bus.re1      = r1;
    bus.raddr1   = 5'(a1);
    bus.re2      = r2;
    bus.raddr2   = 5'(a2);
    bus.iss_en   = ie;
    bus.iss_addr = 5'(ia);
  endtask

  // Issue one cycle: record the expected response, then advance the model at the edge.
  task automatic step();
    exp_q.push_back(expect_now());
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("rdata1", bus.rdata1, e.d1);
      chk("busy1",  32'(bus.busy1), 32'(e.b1));
      chk("rdata2", bus.rdata2, e.d2);
      chk("busy2",  32'(bus.busy2), 32'(e.b2));
      chk("sb_err", 32'(bus.sb_err), 32'(e.err));
    end
  end

  function automatic int rand_addr();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 31));
    return int'($urandom_range(0, 7));
  endfunction

  initial begin
    // Initial reset, unchecked until state is defined.
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    model_update();
    #1;
    // Reset override on reads while rst is high.
    set_in(1, 1, 1, 4, 32'h55, 1, 4, 1, 4, 1, 4);
    step();

    // 1: all registers read zero and idle.
    for (int r = 0; r < 32; r++) begin
      set_in(0, 1, 0, 0, 0, 1, r, 1, 31 - r, 0, 0);
      step();
    end

    // 2: write x5 with bypass, then read back.
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 5);
    step();
    set_in(0, 1, 1, 5, 32'hDEADBEEF, 1, 5, 1, 5, 0, 0);
    step();
    set_in(0, 1, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    step();

    // 3: two writers pending on x7.
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    step();
    step();
    set_in(0, 1, 1, 7, 32'd1, 1, 7, 1, 7, 0, 0);
    step();
    set_in(0, 1, 1, 7, 32'd2, 1, 7, 0, 0, 0, 0);
    step();
    set_in(0, 1, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    step();

    // 4: x0 is never written or tracked.
    set_in(0, 1, 1, 0, 32'h1234, 1, 0, 1, 0, 1, 0);
    step();
    set_in(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    step();

    // 5: rdy low freezes write and issue.
    set_in(0, 0, 1, 3, 32'd9, 1, 3, 0, 0, 1, 3);
    step();
    set_in(0, 1, 0, 0, 0, 1, 3, 1, 3, 0, 0);
    step();

    // 6: counter overflow on x9, then underflow attempt on x10.
    for (int k = 0; k < 4; k++) begin
      set_in(0, 1, 0, 0, 0, 1, 9, 0, 0, 1, 9);
      step();
    end
    set_in(0, 1, 0, 0, 0, 1, 9, 0, 0, 0, 0);
    step();
    set_in(0, 1, 1, 10, 32'hA5A5, 1, 10, 1, 9, 0, 0);
    step();
    set_in(0, 1, 0, 0, 0, 1, 10, 1, 9, 0, 0);
    step();

    // Random traffic with occasional reset and stalls.
    for (int n = 0; n < 3000; n++) begin
      set_in(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) != 0),
             ($urandom_range(0, 2) == 0), rand_addr(), $urandom(),
             ($urandom_range(0, 7) != 0), rand_addr(),
             ($urandom_range(0, 7) != 0), rand_addr(),
             ($urandom_range(0, 2) == 0), rand_addr());
      step();
    end

    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
